vga_timing_gen: RTL and testbench

Parametrised raster timing generator and pixel output stage for the DVI/VGA path. It counts the pixel and line position and produces registered sync, blank and data-enable signals. It requests pixel data from a pixel-clock-synchronous FIFO and can repeat each pixel in X or Y (pixel doubling). It detects FIFO underflow and can substitute a test picture; its outputs feed the analog VGA pins or the TMDS encoder.

---
 rtl/vga_timing_pkg.sv | 52 +++++
 rtl/vga_timing_gen_if.sv | 40 ++++
 rtl/vga_axis_counter.sv | 58 +++++
 rtl/vga_timing_gen.sv | 167 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared mode constants, polarity levels and timing helpers for the raster generator.
// Derived positions are plain ints so they can feed parameters at elaboration.
package vga_timing_pkg;

    typedef struct packed {
        int res;
        int front_porch;
        int pulse;
        int back_porch;
    } axis_mode_t;

    typedef struct packed {
        axis_mode_t h;
        axis_mode_t v;
    } vga_mode_t;

    typedef struct packed {
        int total;
        int sync_start;
        int sync_end;
    } axis_timing_t;

    localparam logic POL_POSITIVE = 1'b1;
    localparam logic POL_NEGATIVE = 1'b0;

    localparam vga_mode_t MODE_640X480_60 = '{
        h: '{res: 640,  front_porch: 16,  pulse: 96,  back_porch: 48},
        v: '{res: 480,  front_porch: 10,  pulse: 2,   back_porch: 33}
    };
    localparam vga_mode_t MODE_800X600_60 = '{
        h: '{res: 800,  front_porch: 40,  pulse: 128, back_porch: 88},
        v: '{res: 600,  front_porch: 1,   pulse: 4,   back_porch: 23}
    };
    localparam vga_mode_t MODE_1280X720_60 = '{
        h: '{res: 1280, front_porch: 110, pulse: 40,  back_porch: 220},
        v: '{res: 720,  front_porch: 5,   pulse: 5,   back_porch: 20}
    };

    function automatic axis_timing_t axis_timing(input int res, input int front_porch,
                                                 input int pulse, input int back_porch);
        axis_timing_t t;
        t.total      = res + front_porch + pulse + back_porch;
        t.sync_start = res + front_porch;
        t.sync_end   = res + front_porch + pulse;
        return t;
    endfunction

    function automatic logic sync_level(input logic in_pulse, input logic polarity);
        return in_pulse ? polarity : ~polarity;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the raster generator: FIFO handshake, beam position and VGA pins.
interface vga_timing_gen_if #(
    parameter int BITS_X = 10,
    parameter int BITS_Y = 10
);
    logic              clk_pixel_ena;
    logic              test_picture;
    logic              pixel_valid;
    logic [7:0]        r_i;
    logic [7:0]        g_i;
    logic [7:0]        b_i;
    logic              underflow_clr;
    logic              fetch_next;
    logic              line_replay;
    logic [BITS_X-1:0] beam_x;
    logic [BITS_Y-1:0] beam_y;
    logic              frame_start;
    logic              underflow;
    logic [7:0]        vga_r;
    logic [7:0]        vga_g;
    logic [7:0]        vga_b;
    logic              vga_hsync;
    logic              vga_vsync;
    logic              vga_vblank;
    logic              vga_blank;
    logic              vga_de;

    modport master (
        input  clk_pixel_ena, test_picture, pixel_valid, r_i, g_i, b_i, underflow_clr,
        output fetch_next, line_replay, beam_x, beam_y, frame_start, underflow,
               vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_vblank, vga_blank, vga_de
    );

    modport slave (
        output clk_pixel_ena, test_picture, pixel_valid, r_i, g_i, b_i, underflow_clr,
        input  fetch_next, line_replay, beam_x, beam_y, frame_start, underflow,
               vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_vblank, vga_blank, vga_de
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with active-region and sync-pulse decode.
// wrap is the qualified terminal step, so chaining wrap into the next axis's increment cascades.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   TOTAL       = 800,
    parameter int   ACTIVE      = 640,
    parameter int   FRONT_PORCH = 16,
    parameter int   PULSE       = 96,
    parameter logic POLARITY    = POL_POSITIVE,
    parameter int   WIDTH       = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             increment,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             active,
    output logic             sync
);

    localparam axis_timing_t TIM = axis_timing(ACTIVE, FRONT_PORCH, PULSE,
                                               TOTAL - ACTIVE - FRONT_PORCH - PULSE);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(TOTAL - 1);

    if (TIM.total - 1 >= (2 ** WIDTH)) begin : g_width_check
        $error("vga_axis_counter: total-1 (%0d) does not fit in %0d bits", TIM.total - 1, WIDTH);
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             terminal;
    logic             in_pulse;

    always_comb begin
        terminal = (count_q == LAST);
        count_d  = count_q;
        if (enable && increment) begin
            count_d = terminal ? '0 : count_q + 1'b1;
        end
        in_pulse = (int'(count_q) >= TIM.sync_start) && (int'(count_q) < TIM.sync_end);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign wrap   = enable && increment && terminal;
    assign active = int'(count_q) < ACTIVE;
    assign sync   = sync_level(in_pulse, POLARITY);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator and pixel output stage: position counters, repetition tracking,
// FIFO/test-pattern data mux, sticky underflow and the registered VGA/DVI outputs.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   c_resolution_x      = MODE_640X480_60.h.res,
    parameter int   c_hsync_front_porch = MODE_640X480_60.h.front_porch,
    parameter int   c_hsync_pulse       = MODE_640X480_60.h.pulse,
    parameter int   c_hsync_back_porch  = MODE_640X480_60.h.back_porch,
    parameter int   c_resolution_y      = MODE_640X480_60.v.res,
    parameter int   c_vsync_front_porch = MODE_640X480_60.v.front_porch,
    parameter int   c_vsync_pulse       = MODE_640X480_60.v.pulse,
    parameter int   c_vsync_back_porch  = MODE_640X480_60.v.back_porch,
    parameter int   c_bits_x            = 10,
    parameter int   c_bits_y            = 10,
    parameter logic c_hsync_polarity    = POL_POSITIVE,
    parameter logic c_vsync_polarity    = POL_POSITIVE,
    parameter int   c_rep_x             = 1,
    parameter int   c_rep_y             = 1
) (
    input  logic             clk_pixel,
    input  logic             reset,
    vga_timing_gen_if.master vga
);

    localparam axis_timing_t H_TIM = axis_timing(c_resolution_x, c_hsync_front_porch,
                                                 c_hsync_pulse, c_hsync_back_porch);
    localparam axis_timing_t V_TIM = axis_timing(c_resolution_y, c_vsync_front_porch,
                                                 c_vsync_pulse, c_vsync_back_porch);
    localparam logic [1:0] REP_X_LAST = 2'(c_rep_x - 1);
    localparam logic [1:0] REP_Y_LAST = 2'(c_rep_y - 1);

    if (!(c_rep_x == 1 || c_rep_x == 2 || c_rep_x == 4) || (c_resolution_x % c_rep_x) != 0) begin : g_rep_x_check
        $error("vga_timing_gen: c_rep_x must be 1, 2 or 4 and divide c_resolution_x");
    end
    if (!(c_rep_y == 1 || c_rep_y == 2 || c_rep_y == 4) || (c_resolution_y % c_rep_y) != 0) begin : g_rep_y_check
        $error("vga_timing_gen: c_rep_y must be 1, 2 or 4 and divide c_resolution_y");
    end

    logic [c_bits_x-1:0] x_count;
    logic [c_bits_y-1:0] y_count;
    logic x_wrap, x_active, x_sync;
    logic y_wrap, y_active, y_sync;

    vga_axis_counter #(
        .TOTAL(H_TIM.total), .ACTIVE(c_resolution_x), .FRONT_PORCH(c_hsync_front_porch),
        .PULSE(c_hsync_pulse), .POLARITY(c_hsync_polarity), .WIDTH(c_bits_x)
    ) u_x_counter (
        .clk(clk_pixel), .reset(reset), .enable(1'b1), .increment(vga.clk_pixel_ena),
        .count(x_count), .wrap(x_wrap), .active(x_active), .sync(x_sync)
    );

    vga_axis_counter #(
        .TOTAL(V_TIM.total), .ACTIVE(c_resolution_y), .FRONT_PORCH(c_vsync_front_porch),
        .PULSE(c_vsync_pulse), .POLARITY(c_vsync_polarity), .WIDTH(c_bits_y)
    ) u_y_counter (
        .clk(clk_pixel), .reset(reset), .enable(1'b1), .increment(x_wrap),
        .count(y_count), .wrap(y_wrap), .active(y_active), .sync(y_sync)
    );

    logic [1:0] rep_x_q, rep_x_d, rep_y_q, rep_y_d;
    logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic hsync_q, hsync_d, vsync_q, vsync_d, vblank_q, vblank_d;
    logic blank_q, blank_d, de_q, de_d, frame_start_q, frame_start_d;
    logic line_replay_q, line_replay_d, fetch_next_q, fetch_next_d;
    logic underflow_q, underflow_d;
    logic emit_active, underflow_set;

    // Repetition phases restart at every line/frame start, so they equal x%rep and y%rep
    // even when the totals are not multiples of the repetition factor.
    always_comb begin
        rep_x_d       = rep_x_q;
        rep_y_d       = rep_y_q;
        r_d           = r_q;
        g_d           = g_q;
        b_d           = b_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        vblank_d      = vblank_q;
        blank_d       = blank_q;
        de_d          = de_q;
        frame_start_d = frame_start_q;
        line_replay_d = line_replay_q;
        fetch_next_d  = 1'b0;
        emit_active   = x_active && y_active;
        underflow_set = vga.clk_pixel_ena && emit_active && !vga.pixel_valid && !vga.test_picture;

        if (vga.clk_pixel_ena) begin
            rep_x_d = (x_wrap || rep_x_q == REP_X_LAST) ? 2'd0 : rep_x_q + 2'd1;
            if (x_wrap) begin
                rep_y_d = (y_wrap || rep_y_q == REP_Y_LAST) ? 2'd0 : rep_y_q + 2'd1;
            end
            de_d          = emit_active;
            blank_d       = !emit_active;
            vblank_d      = !y_active;
            hsync_d       = x_sync;
            vsync_d       = y_sync;
            frame_start_d = (x_count == '0) && (y_count == '0);
            line_replay_d = emit_active && (rep_y_q != REP_Y_LAST);
            fetch_next_d  = emit_active && (rep_x_q == REP_X_LAST);
            r_d = 8'd0;
            g_d = 8'd0;
            b_d = 8'd0;
            if (emit_active && vga.test_picture) begin
                r_d = 8'(x_count);
                g_d = 8'(y_count);
                b_d = 8'(x_count) ^ 8'(y_count);
            end else if (emit_active && vga.pixel_valid) begin
                r_d = vga.r_i;
                g_d = vga.g_i;
                b_d = vga.b_i;
            end
        end

        underflow_d = underflow_set || (underflow_q && !vga.underflow_clr);
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            rep_x_q       <= 2'd0;
            rep_y_q       <= 2'd0;
            r_q           <= 8'd0;
            g_q           <= 8'd0;
            b_q           <= 8'd0;
            hsync_q       <= ~c_hsync_polarity;
            vsync_q       <= ~c_vsync_polarity;
            vblank_q      <= 1'b0;
            blank_q       <= 1'b1;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
            line_replay_q <= 1'b0;
            fetch_next_q  <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            rep_x_q       <= rep_x_d;
            rep_y_q       <= rep_y_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            vblank_q      <= vblank_d;
            blank_q       <= blank_d;
            de_q          <= de_d;
            frame_start_q <= frame_start_d;
            line_replay_q <= line_replay_d;
            fetch_next_q  <= fetch_next_d;
            underflow_q   <= underflow_d;
        end
    end

    assign vga.beam_x      = x_count;
    assign vga.beam_y      = y_count;
    assign vga.vga_r       = r_q;
    assign vga.vga_g       = g_q;
    assign vga.vga_b       = b_q;
    assign vga.vga_hsync   = hsync_q;
    assign vga.vga_vsync   = vsync_q;
    assign vga.vga_vblank  = vblank_q;
    assign vga.vga_blank   = blank_q;
    assign vga.vga_de      = de_q;
    assign vga.frame_start = frame_start_q;
    assign vga.line_replay = line_replay_q;
    assign vga.fetch_next  = fetch_next_q;
    assign vga.underflow   = underflow_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen in a tiny 8x4 mode with 2x2 repetition and mixed
// sync polarity; a frame-linear position model predicts every output after every clock.
module tb_vga_timing_gen;

    localparam int RES_X = 8, HFP = 2, HP = 2, HBP = 2;
    localparam int RES_Y = 4, VFP = 1, VP = 1, VBP = 1;
    localparam int H_TOT = RES_X + HFP + HP + HBP;
    localparam int V_TOT = RES_Y + VFP + VP + VBP;
    localparam int REP_X = 2, REP_Y = 2;
    localparam bit HPOL = 1'b0, VPOL = 1'b1;

    typedef struct packed {
        logic [3:0] bx;
        logic [2:0] by;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic hs, vs, vb, bl, de, fs, lr, fn, uf;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int de_cnt = 0, fn_cnt = 0, fs_cnt = 0, hs_cnt = 0, vs_cnt = 0;

    obs_t exp_q[$];
    bit   tag_q[$];
    obs_t model;
    int   pos;
    logic [7:0] fifo_val;

    vga_timing_gen_if #(.BITS_X(4), .BITS_Y(3)) vif ();

    vga_timing_gen #(
        .c_resolution_x(RES_X), .c_hsync_front_porch(HFP), .c_hsync_pulse(HP), .c_hsync_back_porch(HBP),
        .c_resolution_y(RES_Y), .c_vsync_front_porch(VFP), .c_vsync_pulse(VP), .c_vsync_back_porch(VBP),
        .c_bits_x(4), .c_bits_y(3), .c_hsync_polarity(HPOL), .c_vsync_polarity(VPOL),
        .c_rep_x(REP_X), .c_rep_y(REP_Y)
    ) dut (
        .clk_pixel(clk),
        .reset(rst),
        .vga(vif)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        pos      = 0;
        model    = '0;
        model.bl = 1'b1;
        model.hs = !HPOL;
        model.vs = !VPOL;
    endtask

    // Drive one clock of inputs, predict the outputs that follow the next rising edge.
    task automatic applyStimulus(input bit r_st, input bit ena, input bit tp, input bit pv,
                                 input logic [7:0] ri, input logic [7:0] gi, input logic [7:0] bi,
                                 input bit clr, input bit tag);
        int x, y;
        bit act, set;
        rst               = r_st;
        vif.clk_pixel_ena = ena;
        vif.test_picture  = tp;
        vif.pixel_valid   = pv;
        vif.r_i           = ri;
        vif.g_i           = gi;
        vif.b_i           = bi;
        vif.underflow_clr = clr;
        set = 1'b0;
        if (r_st) begin
            model_reset();
        end else begin
            model.fn = 1'b0;
            if (ena) begin
                x   = pos % H_TOT;
                y   = pos / H_TOT;
                act = (x < RES_X) && (y < RES_Y);
                model.de = act;
                model.bl = !act;
                model.vb = (y >= RES_Y);
                model.hs = (x >= RES_X + HFP && x < RES_X + HFP + HP) ? HPOL : !HPOL;
                model.vs = (y >= RES_Y + VFP && y < RES_Y + VFP + VP) ? VPOL : !VPOL;
                model.fs = (pos == 0);
                model.lr = act && (y % REP_Y != REP_Y - 1);
                model.fn = act && (x % REP_X == REP_X - 1);
                if (!act) begin
                    model.r = 8'd0; model.g = 8'd0; model.b = 8'd0;
                end else if (tp) begin
                    model.r = 8'(x); model.g = 8'(y); model.b = 8'(x) ^ 8'(y);
                end else if (pv) begin
                    model.r = ri; model.g = gi; model.b = bi;
                end else begin
                    model.r = 8'd0; model.g = 8'd0; model.b = 8'd0;
                end
                set = act && !pv && !tp;
                pos = (pos + 1) % (H_TOT * V_TOT);
            end
            model.uf = set || (model.uf && !clr);
            model.bx = 4'(pos % H_TOT);
            model.by = 3'(pos / H_TOT);
        end
        exp_q.push_back(model);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int required);
        tests++;
        if (actual != required) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    // Monitor: the DUT presents a fresh output set every clock; compare it mid-cycle.
    always @(negedge clk) begin
        obs_t act, e;
        bit t;
        cycle++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            act = {vif.beam_x, vif.beam_y, vif.vga_r, vif.vga_g, vif.vga_b,
                   vif.vga_hsync, vif.vga_vsync, vif.vga_vblank, vif.vga_blank, vif.vga_de,
                   vif.frame_start, vif.line_replay, vif.fetch_next, vif.underflow};
            tests++;
            if (act !== e) begin
                fails++;
                $display("[TB] FAIL outputs at cycle %0d: got %h, expected %h", cycle, act, e);
            end
            if (t) begin
                de_cnt += int'(act.de);
                fn_cnt += int'(act.fn);
                fs_cnt += int'(act.fs);
                hs_cnt += (act.hs === HPOL) ? 1 : 0;
                vs_cnt += (act.vs === VPOL) ? 1 : 0;
            end
        end
    end

    initial begin
        bit tp_sticky;
        int ena_mode;
        model_reset();
        fifo_val = 8'h11;

        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 1, 8'h0, 8'h0, 8'h0, 0, 0);

        // Two full frames of test picture with ena tied high.
        for (int i = 0; i < 2 * H_TOT * V_TOT; i++)
            applyStimulus(0, 1, 1, 1, 8'($urandom), 8'($urandom), 8'($urandom), 0, 1);
        @(negedge clk); #1;
        checkOutput("de_clocks_2frames", de_cnt, 2 * RES_X * RES_Y);
        checkOutput("fetch_pulses_2frames", fn_cnt, 2 * (RES_X / REP_X) * RES_Y);
        checkOutput("frame_starts_2frames", fs_cnt, 2);
        checkOutput("hsync_clocks_2frames", hs_cnt, 2 * HP * V_TOT);
        checkOutput("vsync_clocks_2frames", vs_cnt, 2 * VP * H_TOT);

        // FIFO source stepping on fetch_next, ena every third clock.
        for (int i = 0; i < 3 * H_TOT * V_TOT; i++) begin
            applyStimulus(0, (i % 3) == 0, 0, 1, fifo_val, fifo_val, fifo_val, 0, 0);
            if (model.fn) fifo_val = (fifo_val == 8'hFF) ? 8'h11 : fifo_val + 8'h11;
        end

        // Underflow at pixel (3,0) with a simultaneous clear, then a later clear.
        applyStimulus(1, 1, 0, 1, 8'h0, 8'h0, 8'h0, 0, 0);
        for (int i = 0; i < 25; i++) begin
            int emitted;
            emitted = pos;
            applyStimulus(0, 1, 0, emitted != 3, 8'hA5, 8'h5A, 8'hC3, (emitted == 3) || (i == 20), 0);
            if (emitted == 3) begin
                checkOutput("underflow_pixel_r", vif.vga_r, 0);
                checkOutput("underflow_pixel_b", vif.vga_b, 0);
                checkOutput("underflow_set_wins_clear", vif.underflow, 1);
            end
            if (i == 20) checkOutput("underflow_cleared", vif.underflow, 0);
        end

        // Reset while the beam sits at (5,2).
        applyStimulus(1, 1, 1, 1, 8'h0, 8'h0, 8'h0, 0, 0);
        while (pos != 2 * H_TOT + 5) applyStimulus(0, 1, 1, 1, 8'h0, 8'h0, 8'h0, 0, 0);
        applyStimulus(1, 1, 1, 1, 8'h0, 8'h0, 8'h0, 0, 0);
        checkOutput("midreset_de", vif.vga_de, 0);
        checkOutput("midreset_blank", vif.vga_blank, 1);
        checkOutput("midreset_beam_x", vif.beam_x, 0);
        checkOutput("midreset_beam_y", vif.beam_y, 0);
        applyStimulus(0, 1, 1, 1, 8'h0, 8'h0, 8'h0, 0, 0);
        checkOutput("first_frame_start", vif.frame_start, 1);
        checkOutput("first_de", vif.vga_de, 1);
        checkOutput("first_rgb", {vif.vga_r, vif.vga_g, vif.vga_b}, 0);
        checkOutput("first_beam_x", vif.beam_x, 1);
        applyStimulus(0, 1, 1, 1, 8'h0, 8'h0, 8'h0, 0, 0);
        checkOutput("second_rgb", {vif.vga_r, vif.vga_g, vif.vga_b}, 24'h010001);

        // Randomized traffic: varying ena duty, sticky test picture, sparse underflows and resets.
        tp_sticky = 1'b0;
        for (int i = 0; i < 2400; i++) begin
            bit ena;
            ena_mode = (i / 300) % 3;
            if ($urandom_range(63) == 0) tp_sticky = !tp_sticky;
            case (ena_mode)
                0:       ena = 1'b1;
                1:       ena = $urandom_range(1) == 1;
                default: ena = $urandom_range(3) == 0;
            endcase
            applyStimulus($urandom_range(399) == 0, ena, tp_sticky, $urandom_range(9) != 0,
                          8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(15) == 0, 0);
        end

        @(negedge clk); #1;
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
